// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   trial;

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, shift-subtract step and result capture on DONE entry.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      trial   = '0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               q_d   = dividend_i;
               d_d   = divisor_i;
               r_d   = '0;
               cnt_d = CW'(WIDTH - 1);
               dz_d  = 1'b0;
               if (divisor_i == '0) begin
                  // Zero divisor short-circuits straight to DONE with saturated quotient.
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = dividend_i;
                  dz_d    = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            // WIDTH+1-bit trial keeps the shifted-out remainder MSB.
            trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
            if (trial >= {1'b0, d_q}) begin
               r_d = trial - {1'b0, d_q};
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = trial;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               quot_d  = q_d;
               rem_d   = r_d[WIDTH-1:0];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quot_q;
   assign remainder_o   = rem_q;
   assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider with an expected-result scoreboard.
module tb_seq_divider;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         start_i = 1'b0;
   logic [W-1:0] dividend_i = '0;
   logic [W-1:0] divisor_i = '0;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] quotient_o;
   logic [W-1:0] remainder_o;
   logic         div_by_zero_o;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .quotient_o   (quotient_o),
      .remainder_o  (remainder_o),
      .div_by_zero_o(div_by_zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] n, input logic [W-1:0] d);
      exp_t e;
      if (d == '0) begin
         e.q = '1; e.r = n; e.dz = 1'b1;
      end else begin
         e.q = W'(n / d); e.r = W'(n % d); e.dz = 1'b0;
      end
      sb.push_back(e);
   endtask

   task automatic check_pop(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: observed result with empty scoreboard expected none", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " quotient"}, 32'(quotient_o), 32'(e.q));
         chk({tag, " remainder"}, 32'(remainder_o), 32'(e.r));
         chk({tag, " div_by_zero"}, 32'(div_by_zero_o), 32'(e.dz));
      end
   endtask

   // One full operation: returns at the negedge where done_o is seen.
   task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input string tag);
      int cyc;
      @(negedge clk_i);
      chk({tag, " idle busy"}, 32'(busy_o), 32'd0);
      dividend_i = n;
      divisor_i  = d;
      start_i    = 1'b1;
      push_exp(n, d);
      @(negedge clk_i);
      start_i    = 1'b0;
      dividend_i = 'x;
      divisor_i  = 'x;
      cyc = 1;
      while (!done_o && cyc < 40) begin
         @(negedge clk_i);
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), (d == '0) ? 32'd1 : 32'(W + 1));
      chk({tag, " busy at done"}, 32'(busy_o), 32'd1);
      check_pop(tag);
   endtask

   initial begin
      int           cyc;
      int           t[3];
      logic         seen;
      logic [W-1:0] rn, rd;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset done", 32'(done_o), 32'd0);
      chk("reset quotient", 32'(quotient_o), 32'd0);
      chk("reset remainder", 32'(remainder_o), 32'd0);
      chk("reset dz", 32'(div_by_zero_o), 32'd0);
      rst_ni = 1'b1;

      do_op(8'd100, 8'd7, "100/7");
      @(negedge clk_i);
      chk("100/7 done pulse width", 32'(done_o), 32'd0);
      chk("100/7 busy after done", 32'(busy_o), 32'd0);
      chk("100/7 results held", 32'(quotient_o), 32'd14);
      do_op(8'd255, 8'd1, "255/1");
      do_op(8'd5, 8'd9, "5/9");
      do_op(8'd255, 8'd255, "255/255");
      do_op(8'd37, 8'd0, "37/0");
      do_op(8'd10, 8'd3, "10/3");

      // start_i pulsed mid-CALC must be ignored
      @(negedge clk_i);
      dividend_i = 8'd200; divisor_i = 8'd3; start_i = 1'b1;
      push_exp(8'd200, 8'd3);
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 1;
      repeat (2) begin @(negedge clk_i); cyc++; end
      dividend_i = 8'd9; divisor_i = 8'd2; start_i = 1'b1;
      repeat (2) begin @(negedge clk_i); cyc++; end
      start_i = 1'b0;
      while (!done_o && cyc < 40) begin @(negedge clk_i); cyc++; end
      chk("200/3 ignore latency", 32'(cyc), 32'(W + 1));
      check_pop("200/3 ignore");

      // Reset in the middle of CALC
      @(negedge clk_i);
      @(negedge clk_i);
      dividend_i = 8'd100; divisor_i = 8'd7; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("abort quotient", 32'(quotient_o), 32'd0);
      chk("abort remainder", 32'(remainder_o), 32'd0);
      chk("abort busy", 32'(busy_o), 32'd0);
      chk("abort done", 32'(done_o), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
      end
      chk("abort no done", 32'(seen), 32'd0);
      do_op(8'd50, 8'd5, "50/5");

      // start_i held high: re-accept every WIDTH+2 cycles
      @(negedge clk_i);
      dividend_i = 8'd100; divisor_i = 8'd7; start_i = 1'b1;
      for (int k = 0; k < 3; k++) push_exp(8'd100, 8'd7);
      cyc = 0;
      for (int k = 0; k < 3; k++) begin
         do begin
            @(negedge clk_i);
            cyc++;
         end while (!done_o && cyc < 100);
         t[k] = cyc;
         if (k == 2) start_i = 1'b0;
         check_pop("held 100/7");
      end
      chk("held first latency", 32'(t[0]), 32'(W + 1));
      chk("held interval 1", 32'(t[1] - t[0]), 32'(W + 2));
      chk("held interval 2", 32'(t[2] - t[1]), 32'(W + 2));
      @(negedge clk_i);
      chk("held release busy", 32'(busy_o), 32'd0);

      // Random operands, including some zero divisors
      for (int i = 0; i < 300; i++) begin
         rn = W'($urandom_range(0, 255));
         rd = (i % 23 == 0) ? '0 : W'($urandom_range(1, 255));
         do_op(rn, rd, "random");
         if (rd != '0) begin
            chk("random identity", 32'(quotient_o) * 32'(rd) + 32'(remainder_o), 32'(rn));
            chk("random r<d", 32'(remainder_o < rd), 32'd1);
         end
      end

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
